// File: rtl/uart_echo.sv
// uart_echo: far-end echo responder for a uart link.
// Bytes handed over by the uart receiver (rdy/dout/rdy_clr) are queued in a
// small FIFO and replayed, in arrival order, through the uart transmitter
// (din/wr_en/tx_busy). An overflow flag records any byte lost to a full FIFO.
module uart_echo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk_50m,
   input  logic          rst_n,
   input  logic          rx_rdy,
   input  logic [7:0]    rx_data,
   output logic          rx_rdy_clr,
   output logic [7:0]    tx_din,
   output logic          tx_wr_en,
   input  logic          tx_busy,
   output logic [AW:0]   fifo_count,
   output logic          overflow,
   input  logic          ovf_clr
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      R_IDLE,
      R_ACK,
      R_WAIT
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_SEND,
      T_WAIT_HI,
      T_WAIT_LO
   } tx_state_t;

   rx_state_t      rx_state_q, rx_state_d;
   tx_state_t      tx_state_q, tx_state_d;
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    count_q, count_d;
   logic           ovf_q, ovf_d;
   logic [7:0]     tx_din_q;
   logic [1:0]     hi_cnt_q, hi_cnt_d;
   logic [7:0]     mem_q [DEPTH];

   logic           fifo_full;
   logic           fifo_empty;
   logic           push;
   logic           drop;
   logic           pop;

   // Both FSMs decide from the registered count, so a byte written on an
   // edge can never be popped on that same edge.
   assign fifo_full  = (count_q == FULL_LVL);
   assign fifo_empty = (count_q == '0);

   // RX handshake: capture once per rdy assertion, acknowledge, then wait
   // for the receiver to drop rdy before looking for the next byte.
   always_comb begin
      rx_state_d = rx_state_q;
      push       = 1'b0;
      drop       = 1'b0;
      rx_rdy_clr = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (rx_rdy) begin
               if (fifo_full) begin
                  drop = 1'b1;
               end else begin
                  push = 1'b1;
               end
               rx_state_d = R_ACK;
            end
         end
         R_ACK: begin
            rx_rdy_clr = 1'b1;
            rx_state_d = R_WAIT;
         end
         R_WAIT: begin
            if (!rx_rdy) begin
               rx_state_d = R_IDLE;
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // TX sequencing: pop and load din, pulse wr_en, then follow tx_busy
   // high and low. If busy never shows up within three cycles the byte is
   // considered gone so a dead transmitter cannot stall the queue.
   always_comb begin
      tx_state_d = tx_state_q;
      hi_cnt_d   = hi_cnt_q;
      pop        = 1'b0;
      tx_wr_en   = 1'b0;
      case (tx_state_q)
         T_IDLE: begin
            if (!fifo_empty && !tx_busy) begin
               pop        = 1'b1;
               tx_state_d = T_SEND;
            end
         end
         T_SEND: begin
            tx_wr_en   = 1'b1;
            hi_cnt_d   = 2'd0;
            tx_state_d = T_WAIT_HI;
         end
         T_WAIT_HI: begin
            if (tx_busy) begin
               tx_state_d = T_WAIT_LO;
            end else if (hi_cnt_q == 2'd2) begin
               tx_state_d = T_IDLE;
            end else begin
               hi_cnt_d = hi_cnt_q + 2'd1;
            end
         end
         T_WAIT_LO: begin
            if (!tx_busy) begin
               tx_state_d = T_IDLE;
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   // FIFO bookkeeping: pointers wrap naturally at DEPTH (power of two);
   // a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      // A drop on the same edge as a clear keeps the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Storage array, written on push; left without reset so it maps to RAM.
   always_ff @(posedge clk_50m) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   // Control state, pointers, flags and the registered read into tx_din.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= R_IDLE;
         tx_state_q <= T_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         tx_din_q   <= 8'h00;
         hi_cnt_q   <= 2'd0;
      end else begin
         rx_state_q <= rx_state_d;
         tx_state_q <= tx_state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         hi_cnt_q   <= hi_cnt_d;
         if (pop) begin
            tx_din_q <= mem_q[rd_ptr_q];
         end
      end
   end

   assign tx_din     = tx_din_q;
   assign fifo_count = count_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_uart_echo.sv
// tb_uart_echo: drives uart_echo with a behavioural uart receiver/transmitter
// pair and checks every echoed byte, the FIFO level and the overflow flag
// against a queue-based reference model.
module tb_uart_echo;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk_50m = 1'b0;
   logic          rst_n   = 1'b0;
   logic          rx_rdy  = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          tx_busy = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          rx_rdy_clr;
   logic [7:0]    tx_din;
   logic          tx_wr_en;
   logic [AW:0]   fifo_count;
   logic          overflow;

   uart_echo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_50m    (clk_50m),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .rx_rdy_clr (rx_rdy_clr),
      .tx_din     (tx_din),
      .tx_wr_en   (tx_wr_en),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   initial forever #10 clk_50m = ~clk_50m;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference model: bytes acknowledged while the model holds fewer than
   // DEPTH are queued; every start pulse must replay the oldest one.
   logic [7:0] exp_q [$];
   logic [7:0] rx_pend [$];
   int  model_cnt   = 0;
   bit  model_ovf   = 0;
   bit  mon_drop    = 0;
   int  exp_byte    = 0;

   // Behavioural uart pair settings.
   int  rx_low_cnt  = 3;
   int  rx_gap_left = 0;
   int  rx_gap_min  = 0;
   int  rx_gap_max  = 0;
   int  busy_cnt    = 0;
   int  busy_min    = 2;
   int  busy_max    = 3;
   int  timeout_pct = 0;
   bit  hold_busy   = 0;
   bit  never_busy  = 0;

   // Input values seen by the most recent active edge.
   bit  rx_rdy_used  = 0;
   bit  busy_used    = 0;
   bit  ovf_clr_used = 0;
   bit  wr_prev      = 0;
   bit  clr_prev     = 0;

   int  n_echo = 0, n_acc = 0, n_drop = 0, n_both = 0;
   int  last_wr_cyc = 0, wr_gap = 0;
   logic [7:0] last_echo = 8'h00;

   // Monitor, model and uart responders, all evaluated mid-cycle.
   initial forever begin
      @(negedge clk_50m);
      cyc++;
      if (busy_cnt > 0) busy_cnt--;
      if (!rst_n) begin
         exp_q.delete();
         model_cnt = 0;
         model_ovf = 0;
         wr_prev   = 0;
         clr_prev  = 0;
         check_eq("rst_rdy_clr",    int'(rx_rdy_clr), 0);
         check_eq("rst_wr_en",      int'(tx_wr_en),   0);
         check_eq("rst_fifo_count", int'(fifo_count), 0);
         check_eq("rst_overflow",   int'(overflow),   0);
         check_eq("rst_tx_din",     int'(tx_din),     0);
      end else begin
         mon_drop = 0;
         if (rx_rdy_clr) begin
            check_eq("ack_had_rdy", int'(rx_rdy_used), 1);
            check_eq("rdy_clr_pulse", int'(clr_prev), 0);
            if (model_cnt < DEPTH) begin
               exp_q.push_back(rx_data);
               model_cnt++;
               n_acc++;
            end else begin
               mon_drop = 1;
               n_drop++;
               $display("rx drop byte=%02h", rx_data);
            end
            rx_rdy     = 1'b0;
            rx_low_cnt = 0;
         end
         if (mon_drop) model_ovf = 1;
         else if (ovf_clr_used) model_ovf = 0;
         if (tx_wr_en) begin
            check_eq("wr_en_pulse", int'(wr_prev), 0);
            check_eq("wr_en_busy", int'(busy_used), 0);
            exp_byte = -1;
            if (exp_q.size() > 0) begin
               exp_byte = int'(exp_q.pop_front());
               model_cnt--;
            end
            check_eq("tx_din", int'(tx_din), exp_byte);
            if (rx_rdy_clr) n_both++;
            wr_gap      = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            last_echo   = tx_din;
            n_echo++;
            $display("echo %0d: byte=%02h level=%0d", n_echo, tx_din, fifo_count);
            if (!never_busy && $urandom_range(99) >= timeout_pct)
               busy_cnt = $urandom_range(busy_max, busy_min);
         end
         check_eq("fifo_count", int'(fifo_count), model_cnt);
         check_eq("overflow", int'(overflow), int'(model_ovf));
         wr_prev  = tx_wr_en;
         clr_prev = rx_rdy_clr;
      end
      tx_busy = hold_busy || (busy_cnt > 0);
      if (!rx_rdy) begin
         rx_low_cnt++;
         if (rx_low_cnt >= 3 && rx_pend.size() > 0) begin
            if (rx_gap_left > 0) begin
               rx_gap_left--;
            end else begin
               rx_data     = rx_pend.pop_front();
               rx_rdy      = 1'b1;
               rx_gap_left = $urandom_range(rx_gap_max, rx_gap_min);
            end
         end
      end
      rx_rdy_used  = rx_rdy;
      busy_used    = tx_busy;
      ovf_clr_used = ovf_clr;
   end

   task automatic wait_echo(input int target, input int budget);
      int i = 0;
      while (n_echo < target && i < budget) begin
         @(negedge clk_50m);
         i++;
      end
      check_eq("echo_count", n_echo, target);
   endtask

   task automatic drain(input int budget);
      int i = 0;
      while (!(rx_pend.size() == 0 && !rx_rdy && model_cnt == 0 && busy_cnt == 0 && !hold_busy)
             && i < budget) begin
         @(negedge clk_50m);
         i++;
      end
      repeat (8) @(negedge clk_50m);
      check_eq("drain_fifo_count", int'(fifo_count), 0);
   endtask

   task automatic rx_settle(input int budget);
      int i = 0;
      while ((rx_pend.size() > 0 || rx_rdy || rx_low_cnt < 3) && i < budget) begin
         @(negedge clk_50m);
         i++;
      end
      check_eq("rx_settle", int'(rx_pend.size()), 0);
   endtask

   initial begin
      int base;
      int acc_base;
      int both_base;

      // Reset held with a byte already waiting; capture on first edge after release.
      rx_pend.push_back(8'h5A);
      repeat (3) @(posedge clk_50m);
      #1 rst_n = 1'b1;
      @(negedge clk_50m);
      @(negedge clk_50m);
      check_eq("first_capture_ack", int'(rx_rdy_clr), 1);
      wait_echo(1, 50);
      check_eq("first_echo_byte", int'(last_echo), 8'h5A);
      drain(200);

      // Every byte value, back to back, at a rate the echo path can sustain.
      busy_min = 2; busy_max = 3; rx_gap_min = 2; rx_gap_max = 4;
      base = n_echo;
      acc_base = n_acc;
      for (int i = 0; i < 256; i++) rx_pend.push_back(8'(i));
      drain(20000);
      check_eq("sweep_echoed", n_echo - base, 256);
      check_eq("sweep_accepted", n_acc - acc_base, 256);
      check_eq("sweep_overflow", int'(overflow), 0);
      check_eq("sweep_last_byte", int'(last_echo), 8'hFF);

      // Transmitter stalled: 17 bytes into a 16-deep FIFO.
      rx_gap_min = 0; rx_gap_max = 0;
      @(posedge clk_50m); #1 hold_busy = 1;
      for (int i = 0; i <= 16; i++) rx_pend.push_back(8'(i));
      rx_settle(300);
      @(negedge clk_50m);
      check_eq("full_level", int'(fifo_count), DEPTH);
      check_eq("full_overflow", int'(overflow), 1);
      base = n_echo;
      @(posedge clk_50m); #1 hold_busy = 0;
      wait_echo(base + 16, 400);
      check_eq("full_last_byte", int'(last_echo), 8'h0F);
      check_eq("full_sticky", int'(overflow), 1);
      @(posedge clk_50m); #1 ovf_clr = 1'b1;
      @(posedge clk_50m); #1 ovf_clr = 1'b0;
      @(negedge clk_50m);
      check_eq("ovf_cleared", int'(overflow), 0);
      drain(200);

      // One byte queued, then push and pop on the same edge; transmitter
      // never answers so each send ends on the busy timeout.
      @(posedge clk_50m); #1 hold_busy = 1;
      rx_pend.push_back(8'hA1);
      rx_settle(100);
      @(negedge clk_50m);
      check_eq("pp_level_before", int'(fifo_count), 1);
      base = n_echo;
      both_base = n_both;
      never_busy = 1;
      @(posedge clk_50m); #1 hold_busy = 0;
      rx_pend.push_back(8'hA2);
      repeat (3) @(negedge clk_50m);
      check_eq("pp_same_edge", n_both - both_base, 1);
      wait_echo(base + 2, 60);
      check_eq("timeout_gap", wr_gap, 5);
      check_eq("timeout_byte", int'(last_echo), 8'hA2);
      never_busy = 0;
      drain(200);

      // Reset while the transmitter is mid-byte with three bytes still queued.
      busy_min = 30; busy_max = 30;
      @(posedge clk_50m); #1 hold_busy = 1;
      for (int i = 0; i < 4; i++) rx_pend.push_back(8'hB0 + 8'(i));
      rx_settle(100);
      base = n_echo;
      @(posedge clk_50m); #1 hold_busy = 0;
      wait_echo(base + 1, 40);
      repeat (3) @(negedge clk_50m);
      check_eq("mid_level", int'(fifo_count), 3);
      @(posedge clk_50m); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk_50m);
      #1 rst_n = 1'b1;
      repeat (8) @(negedge clk_50m);
      check_eq("post_rst_quiet", n_echo, base + 1);
      check_eq("post_rst_level", int'(fifo_count), 0);
      rx_pend.push_back(8'hC3);
      wait_echo(base + 2, 100);
      check_eq("post_rst_byte", int'(last_echo), 8'hC3);
      busy_min = 2; busy_max = 3;
      drain(300);

      // Random traffic: random data, gaps, busy lengths, missing busy
      // responses and overflow clears racing against drops.
      busy_min = 2; busy_max = 9; timeout_pct = 20;
      rx_gap_min = 0; rx_gap_max = 3;
      base = n_echo;
      acc_base = n_acc;
      for (int i = 0; i < 200; i++) rx_pend.push_back(8'($urandom_range(255)));
      for (int g = 0; g < 20000 && (rx_pend.size() > 0 || rx_rdy); g++) begin
         @(posedge clk_50m);
         #1 ovf_clr = ($urandom_range(19) == 0);
      end
      #1 ovf_clr = 1'b0;
      drain(2000);
      check_eq("rand_echo_vs_acc", n_echo - base, n_acc - acc_base);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #4ms;
      $display("FAIL watchdog: observed timeout, expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
